banked_ram: RTL and testbench



---
 rtl/banked_ram.sv | 152 +++++++++++++++
 tb/tb_banked_ram.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/banked_ram.sv
// Multi-bank synchronous RAM (one write, one read port) with a hardware clear sweep and write-first forwarding.
// Define BANKED_RAM_OUT_REG_EN to add an output register stage (read latency 2 instead of 1).
module banked_ram #(
    parameter int ADDR_LEN = 10,
    parameter int BANK_LEN = 2,
    parameter int DATA_LEN = 8,
    parameter logic [DATA_LEN-1:0] CLR_VAL = '0
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         clr_start,
    input  logic                         wr_en,
    input  logic [BANK_LEN+ADDR_LEN-1:0] wr_addr,
    input  logic [DATA_LEN-1:0]          wr_data,
    input  logic                         rd_en,
    input  logic [BANK_LEN+ADDR_LEN-1:0] rd_addr,
    output logic [DATA_LEN-1:0]          Q,
    output logic                         Q_valid,
    output logic                         busy
);
    localparam int NUM_BANKS = 2 ** BANK_LEN;
    localparam int DEPTH     = 2 ** ADDR_LEN;
    localparam int AW        = BANK_LEN + ADDR_LEN;

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t                state_reg;
    logic [ADDR_LEN-1:0]   clr_ptr_reg;
    logic                  busy_reg;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg   <= ST_CLEAR;
            clr_ptr_reg <= '0;
            busy_reg    <= 1'b1;
        end else begin
            case (state_reg)
                ST_CLEAR: begin
                    clr_ptr_reg <= clr_ptr_reg + 1'b1;
                    if (clr_ptr_reg == {ADDR_LEN{1'b1}}) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (clr_start) begin
                        state_reg   <= ST_CLEAR;
                        clr_ptr_reg <= '0;
                        busy_reg    <= 1'b1;
                    end
                end
                default: state_reg <= ST_CLEAR;
            endcase
        end
    end

    assign busy = busy_reg;

    // The cycle that requests a clear also drops any access presented with it.
    logic clr_we;
    logic access_ok;
    logic wr_accept;
    logic rd_accept;
    logic [BANK_LEN-1:0] wr_bank;
    logic [BANK_LEN-1:0] rd_bank;
    logic [ADDR_LEN-1:0] wr_idx;
    logic [ADDR_LEN-1:0] rd_idx;

    assign clr_we    = (state_reg == ST_CLEAR);
    assign access_ok = (state_reg == ST_IDLE) && !clr_start;
    assign wr_accept = wr_en && access_ok;
    assign rd_accept = rd_en && access_ok;
    assign wr_bank   = wr_addr[AW-1:ADDR_LEN];
    assign rd_bank   = rd_addr[AW-1:ADDR_LEN];
    assign wr_idx    = wr_addr[ADDR_LEN-1:0];
    assign rd_idx    = rd_addr[ADDR_LEN-1:0];

    logic [DATA_LEN-1:0] bank_q [NUM_BANKS];

    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            logic [DATA_LEN-1:0] mem [DEPTH];
            logic [DATA_LEN-1:0] rd_word_reg;

            always_ff @(posedge CLK) begin
                if (clr_we)
                    mem[clr_ptr_reg] <= CLR_VAL;
                else if (wr_accept && wr_bank == BANK_LEN'(gi))
                    mem[wr_idx] <= wr_data;
                if (rd_accept && rd_bank == BANK_LEN'(gi))
                    rd_word_reg <= mem[rd_idx];
            end

            assign bank_q[gi] = rd_word_reg;
        end
    endgenerate

    // Per-bank read registers carry no reset; these tags steer and qualify them.
    logic [BANK_LEN-1:0] rd_bank_reg;
    logic                fwd_reg;
    logic [DATA_LEN-1:0] fwd_data_reg;
    logic                data_live_reg;
    logic                q_valid_reg;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_bank_reg   <= '0;
            fwd_reg       <= 1'b0;
            fwd_data_reg  <= '0;
            data_live_reg <= 1'b0;
            q_valid_reg   <= 1'b0;
        end else begin
            q_valid_reg <= rd_accept;
            if (rd_accept) begin
                rd_bank_reg   <= rd_bank;
                fwd_reg       <= wr_accept && (wr_addr == rd_addr);
                fwd_data_reg  <= wr_data;
                data_live_reg <= 1'b1;
            end
        end
    end

    logic [DATA_LEN-1:0] read_word;

    always_comb begin
        read_word = '0;
        if (data_live_reg)
            read_word = fwd_reg ? fwd_data_reg : bank_q[rd_bank_reg];
    end

`ifdef BANKED_RAM_OUT_REG_EN
    logic [DATA_LEN-1:0] q_out_reg;
    logic                q_valid_out_reg;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            q_out_reg       <= '0;
            q_valid_out_reg <= 1'b0;
        end else begin
            q_out_reg       <= read_word;
            q_valid_out_reg <= q_valid_reg;
        end
    end

    assign Q       = q_out_reg;
    assign Q_valid = q_valid_out_reg;
`else
    assign Q       = read_word;
    assign Q_valid = q_valid_reg;
`endif

endmodule

// File: tb/tb_banked_ram.sv
// Scoreboard bench for banked_ram; honours BANKED_RAM_OUT_REG_EN to expect latency 2.
`timescale 1ns/1ps
module tb_banked_ram;
    localparam int DEPTH = 1024;
`ifdef BANKED_RAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        clr_start = 1'b0;
    logic        wr_en = 1'b0;
    logic [11:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        rd_en = 1'b0;
    logic [11:0] rd_addr = '0;
    logic [7:0]  Q;
    logic        Q_valid;
    logic        busy;

    banked_ram #(.ADDR_LEN(10), .BANK_LEN(2), .DATA_LEN(8), .CLR_VAL(8'h00)) dut (
        .CLK(CLK), .RST_N(RST_N), .clr_start(clr_start),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .Q(Q), .Q_valid(Q_valid), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  data;
        logic [11:0] addr;
        int          due;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model_mem [4096];

    // Output side of the scoreboard: every Q_valid must match the oldest outstanding read.
    always @(negedge CLK) begin
        exp_t e;
        if (RST_N) begin
            if (Q_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: Q_valid=1 Q=%h at cycle %0d, required no valid", Q, cyc);
                end else begin
                    e = sb.pop_front();
                    if (Q !== e.data || cyc != e.due) begin
                        errors++;
                        $display("FAIL read_%h: got Q=%h at cycle %0d, required %h at cycle %0d",
                                 e.addr, Q, cyc, e.data, e.due);
                    end else
                        $display("read  addr=%h Q=%h cycle=%0d", e.addr, Q, cyc);
                end
            end else if (sb.size() != 0 && cyc > sb[0].due) begin
                checks++;
                errors++;
                e = sb.pop_front();
                $display("FAIL missing_read_%h: no Q_valid by cycle %0d, required %h at cycle %0d",
                         e.addr, cyc, e.data, e.due);
            end
        end
    end

    task automatic drive(input logic cs, input logic we, input logic [11:0] wa, input logic [7:0] wd,
                         input logic re, input logic [11:0] ra);
        exp_t e;
        clr_start = cs; wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
        if (!cs) begin
            if (re) begin
                e.data = (we && wa == ra) ? wd : model_mem[ra];
                e.addr = ra;
                e.due  = cyc + LAT;
                sb.push_back(e);
            end
            if (we) begin
                model_mem[wa] = wd;
                $display("write addr=%h data=%h cycle=%0d", wa, wd, cyc);
            end
        end
        @(posedge CLK); #1;
        clr_start = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic measure_busy(output int n);
        n = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            if (busy) n++;
            else break;
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4096; i++) model_mem[i] = 8'h00;
    endtask

    task automatic settle();
        repeat (LAT + 2) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        int n;
        repeat (3) @(posedge CLK);
        #1;
        checks++; if (Q !== 8'h00) begin errors++; $display("FAIL reset_Q: got %h required 00", Q); end
        checks++; if (Q_valid !== 1'b0) begin errors++; $display("FAIL reset_Q_valid: got %b required 0", Q_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b required 1", busy); end
        RST_N = 1'b1;
        measure_busy(n);
        checks++; if (n != DEPTH) begin errors++; $display("FAIL reset_sweep_len: got %0d cycles required %0d", n, DEPTH); end
        $display("sweep after reset busy_cycles=%0d", n);
        clear_model();
        @(posedge CLK); #1;
        drive(0, 0, 12'h000, 8'h00, 1, 12'h000);
        drive(0, 0, 12'h000, 8'h00, 1, 12'hFFF);
        drive(0, 0, 12'h000, 8'h00, 1, 12'h7A3);
        settle();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL default_reads_drained: got %0d pending required 0", sb.size()); end
    endtask

    task automatic test_bank_isolation();
        drive(0, 1, 12'h005, 8'hA5, 0, 12'h000);
        drive(0, 1, 12'hC05, 8'h3C, 0, 12'h000);
        drive(0, 1, 12'hFFF, 8'hC3, 0, 12'h000);
        drive(0, 0, 12'h000, 8'h00, 1, 12'h005);
        drive(0, 0, 12'h000, 8'h00, 1, 12'hC05);
        drive(0, 0, 12'h000, 8'h00, 1, 12'h405);
        drive(0, 0, 12'h000, 8'h00, 1, 12'hFFF);
        drive(0, 0, 12'h000, 8'h00, 1, 12'hBFF);
        settle();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL bank_reads_drained: got %0d pending required 0", sb.size()); end
        checks++; if (Q !== 8'h00) begin errors++; $display("FAIL hold_after_read: got %h required 00", Q); end
    endtask

    task automatic test_read_during_write();
        drive(0, 1, 12'h123, 8'h11, 0, 12'h000);
        drive(0, 1, 12'h123, 8'h7E, 1, 12'h123);
        drive(0, 0, 12'h000, 8'h00, 1, 12'h123);
        drive(0, 1, 12'h123, 8'h7E, 1, 12'h523);
        drive(0, 0, 12'h000, 8'h00, 1, 12'h523);
        drive(0, 1, 12'h124, 8'h42, 1, 12'h123);
        settle();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL rdw_reads_drained: got %0d pending required 0", sb.size()); end
    endtask

    task automatic test_clear_request();
        int n;
        drive(0, 1, 12'h010, 8'h66, 0, 12'h000);
        drive(0, 0, 12'h000, 8'h00, 1, 12'h010);
        settle();
        clr_start = 1'b1; wr_en = 1'b1; wr_addr = 12'h010; wr_data = 8'h99; rd_en = 1'b1; rd_addr = 12'h010;
        @(posedge CLK); #1;
        clr_start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_busy_rise: got %b required 1", busy); end
        measure_busy(n);
        wr_en = 1'b0; rd_en = 1'b0;
        checks++; if (n != DEPTH) begin errors++; $display("FAIL clr_sweep_len: got %0d cycles required %0d", n, DEPTH); end
        checks++; if (Q !== 8'h66) begin errors++; $display("FAIL clr_Q_hold: got %h required 66", Q); end
        $display("sweep on request busy_cycles=%0d", n);
        clear_model();
        @(posedge CLK); #1;
        drive(0, 0, 12'h000, 8'h00, 1, 12'h010);
        drive(0, 0, 12'h000, 8'h00, 1, 12'hC05);
        settle();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL clr_reads_drained: got %0d pending required 0", sb.size()); end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        drive(0, 1, 12'h200, 8'h5A, 0, 12'h000);
        drive(0, 0, 12'h000, 8'h00, 1, 12'h200);
        settle();
        drive(1, 0, 12'h000, 8'h00, 0, 12'h000);
        repeat (500) @(posedge CLK);
        #1;
        RST_N = 1'b0;
        #1;
        checks++; if (Q !== 8'h00) begin errors++; $display("FAIL midreset_Q: got %h required 00", Q); end
        checks++; if (Q_valid !== 1'b0) begin errors++; $display("FAIL midreset_Q_valid: got %b required 0", Q_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset_busy: got %b required 1", busy); end
        @(posedge CLK); #1;
        RST_N = 1'b1;
        measure_busy(n);
        checks++; if (n != DEPTH) begin errors++; $display("FAIL midreset_sweep_len: got %0d cycles required %0d", n, DEPTH); end
        $display("sweep after mid-sweep reset busy_cycles=%0d", n);
        clear_model();
        @(posedge CLK); #1;
        drive(0, 0, 12'h000, 8'h00, 1, 12'h200);
        drive(0, 0, 12'h000, 8'h00, 1, 12'h123);
        settle();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL midreset_reads_drained: got %0d pending required 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_bank_isolation();
        test_read_during_write();
        test_clear_request();
        test_reset_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not complete, required completion within 1 ms");
        $fatal(1, "timeout");
    end

endmodule
